// File: rtl/toggle_rx_pkg.sv
// Shared types and constants for the toggle event receiver.
// ALIGN_CYC follows the TOGGLE_RX_SYNC_EN build macro.
package toggle_rx_pkg;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } rx_state_e;

  localparam int CNT_W_DEF = 4;

`ifdef TOGGLE_RX_SYNC_EN
  localparam int ALIGN_CYC = 2;
`else
  localparam int ALIGN_CYC = 1;
`endif

endpackage

// File: rtl/toggle_event_receiver_if.sv
// Event-credit handshake between the toggle receiver (master) and its consumer (slave).
interface toggle_event_receiver_if
  import toggle_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] pending;

  modport master (output ev_valid, output pending, input ev_ready);
  modport slave  (input ev_valid, input pending, output ev_ready);

endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchronizer, async active-high reset to 0.
// Used only when TOGGLE_RX_SYNC_EN is defined.
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic out_q, out_d;

  always_comb begin
    meta_d = d;
    out_d  = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      out_q  <= out_d;
    end
  end

  assign q = out_q;

endmodule

// File: rtl/toggle_event_receiver.sv
// Receive end of a toggle-signalling link: detects each tog_in level change and queues credits.
// Build macro TOGGLE_RX_SYNC_EN inserts a 2-flop synchronizer on tog_in.
module toggle_event_receiver
  import toggle_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tog_in,
  input  logic                    clr_ovf,
  toggle_event_receiver_if.master ev_if,
  output logic                    ev_pulse,
  output logic                    tog_level,
  output logic                    overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_e        state_q, state_d;
  logic [1:0]       align_cnt_q, align_cnt_d;
  logic             r0;
  logic             prev_q, prev_d;
  logic             ev_pulse_q, ev_pulse_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             detect;
  logic             push;
  logic             pop;
  logic             valid;

`ifdef TOGGLE_RX_SYNC_EN
  // The synchronizer's second stage doubles as the r0 sample register.
  toggle_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tog_in),
    .q     (r0)
  );
`else
  logic r0_q, r0_d;

  always_comb r0_d = tog_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r0_q <= 1'b0;
    else       r0_q <= r0_d;
  end

  assign r0 = r0_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ALIGN;
      align_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
    end
  end

  // Stay in ALIGN until r0 and prev both hold real line samples.
  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    case (state_q)
      ALIGN: begin
        align_cnt_d = align_cnt_q + 2'd1;
        if (align_cnt_q == 2'(ALIGN_CYC)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = ALIGN;
    endcase
  end

  always_comb begin
    prev_d     = r0;
    detect     = (r0 ^ prev_q) && (state_q == RUN);
    valid      = (pending_q != '0);
    push       = detect;
    pop        = valid && ev_if.ev_ready;
    ev_pulse_d = detect;
    pending_d  = pending_q;
    ovf_d      = ovf_q;
    if (push && !pop) begin
      if (pending_q == CNT_MAX) ovf_d = 1'b1;
      else                      pending_d = pending_q + 1'b1;
    end else if (pop && !push) begin
      pending_d = pending_q - 1'b1;
    end
    if (!(push && !pop && (pending_q == CNT_MAX)) && clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= 1'b0;
      ev_pulse_q <= 1'b0;
      ovf_q      <= 1'b0;
      pending_q  <= '0;
    end else begin
      prev_q     <= prev_d;
      ev_pulse_q <= ev_pulse_d;
      ovf_q      <= ovf_d;
      pending_q  <= pending_d;
    end
  end

  assign ev_if.ev_valid = valid;
  assign ev_if.pending  = pending_q;
  assign ev_pulse       = ev_pulse_q;
  assign tog_level      = r0;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: a CNT_W=4 instance plus a CNT_W=2 instance for saturation.
// Honours TOGGLE_RX_SYNC_EN to pick the expected detection latency.
module tb_toggle_event_receiver;

`ifdef TOGGLE_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset;
  logic tog_in, clr_ovf;
  logic ev_pulse, tog_level, overflow;
  logic tog_s, clr_ovf_s;
  logic ev_pulse_s, tog_level_s, overflow_s;

  int vec_cnt = 0;
  int err_cnt = 0;

  toggle_event_receiver_if #(.CNT_W(4)) ev_if ();
  toggle_event_receiver_if #(.CNT_W(2)) ev_if_s ();

  toggle_event_receiver #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tog_in    (tog_in),
    .clr_ovf   (clr_ovf),
    .ev_if     (ev_if),
    .ev_pulse  (ev_pulse),
    .tog_level (tog_level),
    .overflow  (overflow)
  );

  toggle_event_receiver #(.CNT_W(2)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .tog_in    (tog_s),
    .clr_ovf   (clr_ovf_s),
    .ev_if     (ev_if_s),
    .ev_pulse  (ev_pulse_s),
    .tog_level (tog_level_s),
    .overflow  (overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; tog_in = 1'b1; clr_ovf = 1'b0; ev_if.ev_ready = 1'b0;
    tog_s = 1'b0; clr_ovf_s = 1'b0; ev_if_s.ev_ready = 1'b0;
    step(); step();
    vec_cnt++; if (ev_if.ev_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ev_valid got %b exp 0", ev_if.ev_valid); end
    vec_cnt++; if (ev_if.pending !== 4'd0) begin err_cnt++; $display("[TB] FAIL reset_pending got %0d exp 0", ev_if.pending); end
    vec_cnt++; if (ev_pulse !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ev_pulse got %b exp 0", ev_pulse); end
    vec_cnt++; if (tog_level !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_tog_level got %b exp 0", tog_level); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_overflow got %b exp 0", overflow); end
    reset = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step();
      vec_cnt++;
      if (ev_pulse !== 1'b0 || ev_if.pending !== 4'd0) begin
        err_cnt++;
        $display("[TB] FAIL align_quiet cycle %0d got pulse=%b pending=%0d exp pulse=0 pending=0", s, ev_pulse, ev_if.pending);
      end
    end
    vec_cnt++; if (tog_level !== 1'b1) begin err_cnt++; $display("[TB] FAIL tog_level_high got %b exp 1", tog_level); end
  endtask

  task automatic test_events();
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tog_in = ~tog_in;
      for (int s = 1; s <= LAT; s++) begin
        step();
        vec_cnt++;
        if (ev_pulse !== 1'b0 || ev_if.pending !== 4'(i)) begin
          err_cnt++;
          $display("[TB] FAIL event%0d_early got pulse=%b pending=%0d exp pulse=0 pending=%0d", i, ev_pulse, ev_if.pending, i);
        end
      end
      step();
      vec_cnt++;
      if (ev_pulse !== 1'b1 || ev_if.pending !== 4'(i + 1)) begin
        err_cnt++;
        $display("[TB] FAIL event%0d_strobe got pulse=%b pending=%0d exp pulse=1 pending=%0d", i, ev_pulse, ev_if.pending, i + 1);
      end
    end
    step();
    vec_cnt++; if (ev_pulse !== 1'b0) begin err_cnt++; $display("[TB] FAIL event_strobe_width got %b exp 0", ev_pulse); end
    vec_cnt++; if (ev_if.pending !== 4'd3) begin err_cnt++; $display("[TB] FAIL event_pending got %0d exp 3", ev_if.pending); end
    vec_cnt++; if (ev_if.ev_valid !== 1'b1) begin err_cnt++; $display("[TB] FAIL event_valid got %b exp 1", ev_if.ev_valid); end
  endtask

  task automatic test_push_pop();
    ev_if.ev_ready = 1'b1;
    step();
    vec_cnt++; if (ev_if.pending !== 4'd2) begin err_cnt++; $display("[TB] FAIL pop_only got %0d exp 2", ev_if.pending); end
    ev_if.ev_ready = 1'b0;
    tog_in = ~tog_in;
    for (int s = 1; s <= LAT; s++) step();
    ev_if.ev_ready = 1'b1;
    step();
    vec_cnt++;
    if (ev_pulse !== 1'b1 || ev_if.pending !== 4'd2) begin
      err_cnt++;
      $display("[TB] FAIL push_pop got pulse=%b pending=%0d exp pulse=1 pending=2", ev_pulse, ev_if.pending);
    end
    step();
    vec_cnt++; if (ev_if.pending !== 4'd1) begin err_cnt++; $display("[TB] FAIL pop_after got %0d exp 1", ev_if.pending); end
    step();
    vec_cnt++;
    if (ev_if.pending !== 4'd0 || ev_if.ev_valid !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL drain got pending=%0d valid=%b exp pending=0 valid=0", ev_if.pending, ev_if.ev_valid);
    end
    step();
    vec_cnt++; if (ev_if.pending !== 4'd0) begin err_cnt++; $display("[TB] FAIL no_underflow got %0d exp 0", ev_if.pending); end
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tog_in = 1'b0;
    for (int s = 1; s <= LAT; s++) step();
    step();
    vec_cnt++; if (ev_if.pending !== 4'd1) begin err_cnt++; $display("[TB] FAIL b2b_setup got %0d exp 1", ev_if.pending); end
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    vec_cnt++; if (ev_if.pending !== 4'd0) begin err_cnt++; $display("[TB] FAIL b2b_drain got %0d exp 0", ev_if.pending); end
    tog_in = 1'b1;
    for (int s = 1; s <= LAT + 4; s++) begin
      step();
      vec_cnt++;
      if (ev_pulse !== ((s >= LAT + 1) && (s <= LAT + 3))) begin
        err_cnt++;
        $display("[TB] FAIL b2b_pulse step %0d got %b exp %b", s, ev_pulse, ((s >= LAT + 1) && (s <= LAT + 3)));
      end
      if (s == 1) tog_in = 1'b0;
      if (s == 2) tog_in = 1'b1;
    end
    vec_cnt++; if (ev_if.pending !== 4'd3) begin err_cnt++; $display("[TB] FAIL b2b_pending got %0d exp 3", ev_if.pending); end
  endtask

  task automatic test_overflow();
    ev_if_s.ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tog_s = ~tog_s;
      for (int s = 1; s <= LAT; s++) step();
      step();
      vec_cnt++;
      if (ev_pulse_s !== 1'b1 || ev_if_s.pending !== 2'((i > 3) ? 3 : i) || overflow_s !== (i >= 4)) begin
        err_cnt++;
        $display("[TB] FAIL sat_toggle%0d got pulse=%b pending=%0d ovf=%b exp pulse=1 pending=%0d ovf=%b",
                 i, ev_pulse_s, ev_if_s.pending, overflow_s, (i > 3) ? 3 : i, (i >= 4));
      end
    end
    clr_ovf_s = 1'b1;
    step();
    clr_ovf_s = 1'b0;
    vec_cnt++;
    if (overflow_s !== 1'b0 || ev_if_s.pending !== 2'd3) begin
      err_cnt++;
      $display("[TB] FAIL clr_ovf got ovf=%b pending=%0d exp ovf=0 pending=3", overflow_s, ev_if_s.pending);
    end
    tog_s = ~tog_s;
    for (int s = 1; s <= LAT; s++) step();
    clr_ovf_s = 1'b1;
    step();
    clr_ovf_s = 1'b0;
    vec_cnt++; if (overflow_s !== 1'b1) begin err_cnt++; $display("[TB] FAIL set_beats_clr got %b exp 1", overflow_s); end
  endtask

  task automatic test_reset_midstream();
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if (ev_if.pending !== 4'd0 || ev_if.ev_valid !== 1'b0 || ev_pulse !== 1'b0 || tog_level !== 1'b0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL async_reset_big got pending=%0d valid=%b pulse=%b level=%b ovf=%b exp all 0",
               ev_if.pending, ev_if.ev_valid, ev_pulse, tog_level, overflow);
    end
    vec_cnt++;
    if (ev_if_s.pending !== 2'd0 || ev_if_s.ev_valid !== 1'b0 || ev_pulse_s !== 1'b0 || tog_level_s !== 1'b0 || overflow_s !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL async_reset_small got pending=%0d valid=%b pulse=%b level=%b ovf=%b exp all 0",
               ev_if_s.pending, ev_if_s.ev_valid, ev_pulse_s, tog_level_s, overflow_s);
    end
    @(negedge clk);
    tog_s = 1'b1;
    step();
    reset = 1'b0;
    for (int s = 1; s <= LAT + 3; s++) begin
      step();
      vec_cnt++;
      if (ev_pulse_s !== 1'b0 || ev_if_s.pending !== 2'd0 || ev_pulse !== 1'b0 || ev_if.pending !== 4'd0) begin
        err_cnt++;
        $display("[TB] FAIL realign_quiet cycle %0d got pulse_s=%b pend_s=%0d pulse=%b pend=%0d exp all 0",
                 s, ev_pulse_s, ev_if_s.pending, ev_pulse, ev_if.pending);
      end
    end
    tog_s = 1'b0;
    for (int s = 1; s <= LAT; s++) step();
    step();
    vec_cnt++;
    if (ev_pulse_s !== 1'b1 || ev_if_s.pending !== 2'd1) begin
      err_cnt++;
      $display("[TB] FAIL post_reset_event got pulse=%b pending=%0d exp pulse=1 pending=1", ev_pulse_s, ev_if_s.pending);
    end
  endtask

  initial begin
    test_reset();
    test_events();
    test_push_pop();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
